// File: rtl/iob_ethmac_mem_arbiter.sv
// -----------------------------------------------------------------------------
// iob_ethmac_mem_arbiter
//
// Shares one IOb system-memory port between the CPU data port (c_*) and the
// Ethernet MAC DMA master (e_*). One transaction is granted at a time, and the
// grant is held until the memory answers. A watchdog forces completion of any
// transaction the memory leaves unanswered for TIMEOUT cycles. The forced
// completion returns rdata = 32'hDEADBEEF with err = 1, so a stalled memory
// cannot hang the MAC descriptor engine.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   c_valid/c_addr/c_wdata/c_wstrb  CPU request in
//   c_rdata/c_ready/c_err           CPU response out
//   e_valid/e_addr/e_wdata/e_wstrb  Ethernet DMA request in
//   e_rdata/e_ready/e_err           Ethernet DMA response out
//   m_valid/m_addr/m_wdata/m_wstrb  memory request out
//   m_rdata/m_ready                 memory response in
//   timeout_cnt                     saturating count of forced completions
//
// Configuration macro:
//   ETHMAC_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                     undefined -> fixed priority, Ethernet wins contention
// -----------------------------------------------------------------------------
module iob_ethmac_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                c_valid,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_ready,
    output logic                c_err,

    input  logic                e_valid,
    input  logic [ADDR_W-1:0]   e_addr,
    input  logic [DATA_W-1:0]   e_wdata,
    input  logic [DATA_W/8-1:0] e_wstrb,
    output logic [DATA_W-1:0]   e_rdata,
    output logic                e_ready,
    output logic                e_err,

    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,

    output logic [15:0]         timeout_cnt
);

    localparam logic [15:0]       WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] DEAD_WORD = DATA_W'(32'hDEADBEEF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;           // 0 = CPU, 1 = Ethernet
    logic        last_q, last_d;         // last granted requester
    logic [15:0] wd_q, wd_d;             // watchdog, cycles spent in BUSY
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    logic        winner;
    logic        done;
    logic        forced;

    // Arbitration decision, only consumed while IDLE.
    always_comb begin
`ifdef ETHMAC_ARB_RR_EN
        // On contention, the grant goes to whoever was not served last.
        if (c_valid && e_valid) begin
            winner = ~last_q;
        end else begin
            winner = e_valid;
        end
`else
        // Fixed priority. Ethernet wins whenever it is requesting.
        winner = e_valid;
`endif
    end

    // A transaction ends on m_ready, or when the watchdog reaches its last
    // cycle. m_ready in that last cycle still counts as a normal completion.
    assign done   = (state_q == BUSY) && (m_ready || (wd_q == WD_LAST));
    assign forced = (state_q == BUSY) && !m_ready && (wd_q == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            wd_q          <= 16'h0000;
            timeout_cnt_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            wd_q          <= wd_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        wd_d          = wd_q;
        timeout_cnt_d = timeout_cnt_q;

        if (state_q == IDLE) begin
            if (c_valid || e_valid) begin
                gnt_d   = winner;
                last_d  = winner;
                wd_d    = 16'h0000;
                state_d = BUSY;
            end
        end else begin
            wd_d = wd_q + 16'h0001;
            if (done) begin
                state_d = IDLE;
            end
            if (forced && (timeout_cnt_q != 16'hFFFF)) begin
                timeout_cnt_d = timeout_cnt_q + 16'h0001;
            end
        end
    end

    // Output logic: the memory request is muxed from the granted requester,
    // and the response is steered back to that requester with no added latency.
    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        c_ready = 1'b0;
        c_err   = 1'b0;
        c_rdata = '0;
        e_ready = 1'b0;
        e_err   = 1'b0;
        e_rdata = '0;

        if (state_q == BUSY) begin
            m_valid = 1'b1;
            if (gnt_q) begin
                m_addr  = e_addr;
                m_wdata = e_wdata;
                m_wstrb = e_wstrb;
                e_ready = done;
                e_err   = forced;
                e_rdata = forced ? DEAD_WORD : m_rdata;
            end else begin
                m_addr  = c_addr;
                m_wdata = c_wdata;
                m_wstrb = c_wstrb;
                c_ready = done;
                c_err   = forced;
                c_rdata = forced ? DEAD_WORD : m_rdata;
            end
        end
    end

    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_iob_ethmac_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iob_ethmac_mem_arbiter
//
// Self-checking bench for iob_ethmac_mem_arbiter, built with TIMEOUT = 8.
// The bench covers four areas:
//   - reset state;
//   - a table of single transactions (normal, boundary and forced completion);
//   - hand-written sequences for contention and reset during BUSY;
//   - a randomized phase checked cycle by cycle against a behavioural model.
// The grant policy follows ETHMAC_ARB_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_iob_ethmac_mem_arbiter;

    localparam int          TO   = 8;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_valid, e_valid, m_valid;
    logic [31:0] c_addr, c_wdata, e_addr, e_wdata, m_addr, m_wdata;
    logic [3:0]  c_wstrb, e_wstrb, m_wstrb;
    logic [31:0] c_rdata, e_rdata, m_rdata;
    logic        c_ready, c_err, e_ready, e_err, m_ready;
    logic [15:0] timeout_cnt;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic        who;        // 0 = CPU, 1 = Ethernet
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;        // BUSY cycle in which memory answers, 0 = never
        logic [31:0] mrdata;
        int          exp_cycle;  // BUSY cycle in which ready is expected
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] exp_tcnt;

    iob_ethmac_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_valid    (c_valid),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_wstrb    (c_wstrb),
        .c_rdata    (c_rdata),
        .c_ready    (c_ready),
        .c_err      (c_err),
        .e_valid    (e_valid),
        .e_addr     (e_addr),
        .e_wdata    (e_wdata),
        .e_wstrb    (e_wstrb),
        .e_rdata    (e_rdata),
        .e_ready    (e_ready),
        .e_err      (e_err),
        .m_valid    (m_valid),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready),
        .timeout_cnt(timeout_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL time limit: simulation still running, required finish");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        c_valid = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
        e_valid = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        m_ready = 1'b0; m_rdata = '0;
    endtask

    task automatic applyStimulus(input logic who, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        clearInputs();
        if (who) begin
            e_valid = 1'b1; e_addr = addr; e_wdata = wdata; e_wstrb = wstrb;
        end else begin
            c_valid = 1'b1; c_addr = addr; c_wdata = wdata; c_wstrb = wstrb;
        end
    endtask

    // Pulses reset across two edges. Returns just after a rising edge, with
    // reset released.
    task automatic doReset();
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // The grant policy, as seen from outside the block.
    function automatic logic predictWinner(input logic c_req, input logic e_req,
                                           input logic last);
`ifdef ETHMAC_ARB_RR_EN
        if (c_req && e_req) return !last;
        return e_req;
`else
        return e_req;
`endif
    endfunction

    // Runs one table entry as a complete single-requester transaction.
    task automatic runVector(input vec_t v, input int idx);
        int          ready_cycle = 0;
        logic        got_err     = 1'b0;
        logic [31:0] got_rdata   = '0;
        logic        other_seen  = 1'b0;
        logic        stray_err   = 1'b0;
        logic        req_ok      = 1'b1;

        applyStimulus(v.who, v.addr, v.wdata, v.wstrb);
        @(negedge clk);
        checkOutput($sformatf("vec%0d pre-grant m_valid", idx), m_valid, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            m_ready = (k == v.lat);
            m_rdata = (k == v.lat) ? v.mrdata : $urandom;
            @(negedge clk);
            if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, v.addr, v.wdata, v.wstrb})
                req_ok = 1'b0;
            if (v.who ? c_ready : e_ready) other_seen = 1'b1;
            if (v.who ? e_ready : c_ready) begin
                ready_cycle = k;
                got_err     = v.who ? e_err : c_err;
                got_rdata   = v.who ? e_rdata : c_rdata;
            end else if (c_err || e_err) begin
                stray_err = 1'b1;
            end
            @(posedge clk); #1;
            if (ready_cycle != 0) break;
        end
        clearInputs();
        exp_tcnt = exp_tcnt + 16'(v.exp_err);
        @(negedge clk);
        checkOutput($sformatf("vec%0d m request", idx), req_ok, 1);
        checkOutput($sformatf("vec%0d ready cycle", idx), ready_cycle, v.exp_cycle);
        checkOutput($sformatf("vec%0d err", idx), got_err, v.exp_err);
        checkOutput($sformatf("vec%0d rdata", idx), got_rdata, v.exp_rdata);
        checkOutput($sformatf("vec%0d quiet other/err", idx), {other_seen, stray_err}, 0);
        checkOutput($sformatf("vec%0d timeout_cnt", idx), timeout_cnt, exp_tcnt);
        checkOutput($sformatf("vec%0d idle after", idx),
                    {m_valid, m_addr, m_wdata, m_wstrb, c_ready, e_ready, c_err, e_err}, 0);
        @(posedge clk); #1;
    endtask

    // Both requesters keep four transactions each queued behind a 1-cycle
    // memory. The completion order must follow the policy.
    task automatic runContention();
        int   c_left = 4, e_left = 4, done_cnt = 0;
        logic last = 1'b1;
        logic who, exp_who;
        logic advance;

        doReset();
        c_valid = 1'b1; c_addr = 32'h1000; c_wdata = 32'h0; c_wstrb = 4'h0;
        e_valid = 1'b1; e_addr = 32'h2000; e_wdata = 32'h0; e_wstrb = 4'h0;
        m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
        for (int cyc = 0; cyc < 60 && done_cnt < 8; cyc++) begin
            advance = 1'b0;
            @(negedge clk);
            if (c_ready || e_ready) begin
                who     = e_ready;
                exp_who = predictWinner(c_left > 0, e_left > 0, last);
                checkOutput($sformatf("contention order #%0d", done_cnt),
                            {c_ready, e_ready}, {!exp_who, exp_who});
                checkOutput($sformatf("contention addr #%0d", done_cnt),
                            m_addr, exp_who ? e_addr : c_addr);
                last = who;
                if (who) e_left--; else c_left--;
                done_cnt++;
                advance = 1'b1;
            end
            @(posedge clk); #1;
            if (advance) begin
                if (who) begin
                    e_addr  = e_addr + 32'h4;
                    e_valid = (e_left > 0);
                end else begin
                    c_addr  = c_addr + 32'h4;
                    c_valid = (c_left > 0);
                end
            end
        end
        checkOutput("contention completions", done_cnt, 8);
        clearInputs();
        @(posedge clk); #1;
    endtask

    // Reset pulled low while a CPU transaction is in BUSY.
    task automatic runResetMidBusy();
        applyStimulus(1'b0, 32'h500, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mid-busy m_valid before reset", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-busy async drop",
                    {m_valid, c_ready, e_ready, c_err, e_err, timeout_cnt}, 0);
        @(posedge clk); #1;
        checkOutput("mid-busy no ready in reset", {m_valid, c_ready, e_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid-busy idle after release", {m_valid, c_ready}, 0);
        @(posedge clk); #1;
        m_ready = 1'b1; m_rdata = 32'h0000_0077;
        @(negedge clk);
        checkOutput("mid-busy re-arbitrated",
                    {m_valid, m_addr, c_ready, c_err, c_rdata},
                    {1'b1, 32'h500, 1'b1, 1'b0, 32'h0000_0077});
        @(posedge clk); #1;
        clearInputs();
        @(posedge clk); #1;
    endtask

    // Randomized traffic compared against a cycle-level behavioural model.
    task automatic runRandom();
        logic         c_pend = 1'b0, e_pend = 1'b0;
        logic         mdl_busy = 1'b0, mdl_owner = 1'b0, mdl_last = 1'b1;
        int           mdl_age = 0;   // BUSY cycles elapsed, counting from 1
        logic [15:0]  mdl_tcnt = '0;
        logic         exp_done, exp_forced;
        logic [31:0]  exp_rdata, act_rdata;
        logic [127:0] exp_vec, act_vec;

        doReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!c_pend && $urandom_range(0, 2) == 0) begin
                c_pend = 1'b1; c_addr = $urandom; c_wdata = $urandom; c_wstrb = 4'($urandom);
            end
            if (!e_pend && $urandom_range(0, 2) == 0) begin
                e_pend = 1'b1; e_addr = $urandom; e_wdata = $urandom; e_wstrb = 4'($urandom);
            end
            c_valid = c_pend;
            e_valid = e_pend;
            m_ready = ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
            @(negedge clk);

            exp_done   = mdl_busy && (m_ready || mdl_age == TO);
            exp_forced = mdl_busy && !m_ready && (mdl_age == TO);
            exp_rdata  = exp_done ? (exp_forced ? DEAD : m_rdata) : 32'h0;
            if (mdl_busy)
                exp_vec = {7'b0, 1'b1,
                           mdl_owner ? e_addr  : c_addr,
                           mdl_owner ? e_wdata : c_wdata,
                           mdl_owner ? e_wstrb : c_wstrb,
                           exp_done && !mdl_owner, exp_done && mdl_owner,
                           exp_forced && !mdl_owner, exp_forced && mdl_owner,
                           mdl_tcnt, exp_rdata};
            else
                exp_vec = {7'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, mdl_tcnt, 32'h0};
            act_rdata = c_ready ? c_rdata : (e_ready ? e_rdata : 32'h0);
            act_vec   = {7'b0, m_valid, m_addr, m_wdata, m_wstrb,
                         c_ready, e_ready, c_err, e_err, timeout_cnt, act_rdata};
            checkOutput($sformatf("random cycle %0d", cyc), act_vec, exp_vec);

            if (mdl_busy) begin
                if (exp_done) begin
                    mdl_busy = 1'b0;
                    if (mdl_owner) e_pend = 1'b0; else c_pend = 1'b0;
                    if (exp_forced && mdl_tcnt != 16'hFFFF) mdl_tcnt = mdl_tcnt + 16'h1;
                end else begin
                    mdl_age++;
                end
            end else if (c_pend || e_pend) begin
                mdl_owner = predictWinner(c_pend, e_pend, mdl_last);
                mdl_last  = mdl_owner;
                mdl_busy  = 1'b1;
                mdl_age   = 1;
            end
            @(posedge clk); #1;
        end
        clearInputs();
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 2, 32'h1234_5678, 2, 1'b0, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 4'hF, 1, 32'h0,         1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_3000, 32'h0,         4'h0, 0, 32'h0,         TO, 1'b1, DEAD};
        vecs[3] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 1, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 32'h0000_0108, 32'h1122_3344, 4'h3, TO, 32'h0000_55AA, TO, 1'b0, 32'h0000_55AA};
        vecs[5] = '{1'b0, 32'h0000_010C, 32'h0,         4'h0, 0, 32'h0,         TO, 1'b1, DEAD};
        vecs[6] = '{1'b1, 32'h0000_4000, 32'h0,         4'h1, TO-1, 32'h0F0F_0F0F, TO-1, 1'b0, 32'h0F0F_0F0F};
        exp_tcnt = '0;

        // Reset asserted asynchronously before the first edge, with busy inputs.
        rst_n = 1'b1;
        clearInputs();
        #1;
        rst_n = 1'b0;
        c_valid = 1'b1; e_valid = 1'b1; m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
        c_addr = 32'h44; e_addr = 32'h88;
        #2;
        checkOutput("reset outputs",
                    {m_valid, m_addr, m_wdata, m_wstrb, c_ready, e_ready, c_err, e_err, timeout_cnt}, 0);
        checkOutput("reset rdata", {c_rdata, e_rdata}, 0);
        doReset();

        for (int i = 0; i < 7; i++) runVector(vecs[i], i);
        runResetMidBusy();
        runContention();
        runRandom();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
